// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory side of the CPU: word type, RAM
// handshake states and the memory arbiter FSM encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM model handshake state.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter FSM.
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  // Width of a core index; one bit even for a single core.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requesting index at or after
// ptr, wrapping modulo CPUS, wins.
module rr_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  localparam int PTR_W = ptr_width(CPUS)
) (
  input  logic [CPUS-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  localparam logic [PTR_W:0] CPUS_W = (PTR_W + 1)'(CPUS);

  logic [PTR_W:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest
  // requester (highest priority) is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (cand >= CPUS_W) begin
        cand = cand - CPUS_W;
      end
      if (req[cand[PTR_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Responder side of the cache/memory interface. Serializes icache and
// dcache requests from CPUS cores onto one single-port RAM.
//
// Handshake: a requester raises its REN/WEN with address (and store data)
// and holds them until its wait output is 0; wait is 0 for exactly the
// completion cycle, and load data is valid only in that cycle. Dropping the
// request before completion abandons it with no wait pulse.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  localparam int PTR_W = ptr_width(CPUS)
) (
  input  logic                CLK,
  input  logic                nRST,
  // instruction side
  input  logic  [CPUS-1:0]    iREN,
  input  word_t [CPUS-1:0]    iaddr,
  output logic  [CPUS-1:0]    iwait,
  output word_t [CPUS-1:0]    iload,
  // data side
  input  logic  [CPUS-1:0]    dREN,
  input  logic  [CPUS-1:0]    dWEN,
  input  word_t [CPUS-1:0]    daddr,
  input  word_t [CPUS-1:0]    dstore,
  output logic  [CPUS-1:0]    dwait,
  output word_t [CPUS-1:0]    dload,
  // RAM side
  output logic                ramREN,
  output logic                ramWEN,
  output word_t               ramaddr,
  output word_t               ramstore,
  input  word_t               ramload,
  input  ramstate_t           ramstate,
  output logic                ram_err,
  // debug visibility of the FSM
  output arb_state_t          state_o,
  output logic  [PTR_W-1:0]   rr_ptr_o
);

  arb_state_t       state_q;
  logic [PTR_W-1:0] gnt_core_q;
  logic             gnt_isD_q;
  logic [PTR_W-1:0] rr_ptr_q;
  logic             ram_err_q;

  logic [CPUS-1:0]  d_req;
  logic [CPUS-1:0]  any_req;
  logic             arb_valid;
  logic [PTR_W-1:0] arb_idx;
  logic [PTR_W-1:0] rr_ptr_d;

  logic             src_active;
  logic             src_write;
  word_t            src_addr;
  logic             done;

  // A write wins over a read when both are raised by the same dcache.
  assign d_req   = dREN | dWEN;
  assign any_req = d_req | iREN;

  rr_arbiter #(.CPUS(CPUS)) u_rr (
    .req       (any_req),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Live view of the granted source; it is followed every SERVE cycle so a
  // withdrawn request drops the strobes immediately.
  always_comb begin
    src_active = 1'b0;
    src_write  = 1'b0;
    src_addr   = '0;
    if (state_q == SERVE) begin
      if (gnt_isD_q) begin
        src_active = d_req[gnt_core_q];
        src_write  = dWEN[gnt_core_q];
        src_addr   = daddr[gnt_core_q];
      end else begin
        src_active = iREN[gnt_core_q];
        src_addr   = iaddr[gnt_core_q];
      end
    end
  end

  assign done = src_active && (ramstate == ACCESS);

  // RAM strobes, address and store data driven straight from the granted source.
  always_comb begin
    ramREN   = src_active & ~src_write;
    ramWEN   = src_active & src_write;
    ramaddr  = src_active ? src_addr : '0;
    ramstore = (src_active && src_write) ? dstore[gnt_core_q] : '0;
  end

  // Completion pulse and load routing for the granted source only.
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    if (done) begin
      if (gnt_isD_q) begin
        dwait[gnt_core_q] = 1'b0;
        dload[gnt_core_q] = ramload;
      end else begin
        iwait[gnt_core_q] = 1'b0;
        iload[gnt_core_q] = ramload;
      end
    end
  end

  // Round-robin pointer moves just past the core that completed.
  assign rr_ptr_d = (gnt_core_q == PTR_W'(CPUS - 1)) ? '0 : gnt_core_q + PTR_W'(1);

  // Arbitration FSM: grant in IDLE, serve until ACCESS or withdrawal.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gnt_core_q <= '0;
      gnt_isD_q  <= 1'b0;
      rr_ptr_q   <= '0;
      ram_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            gnt_core_q <= arb_idx;
            gnt_isD_q  <= d_req[arb_idx];
            state_q    <= SERVE;
          end
        end
        SERVE: begin
          if (!src_active) begin
            state_q <= IDLE;
          end else if (ramstate == ACCESS) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end else if (ramstate == ERROR) begin
            ram_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_err  = ram_err_q;
  assign state_o  = state_q;
  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with two cores.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 2;

  logic             CLK;
  logic             nRST;
  logic  [N-1:0]    iREN, dREN, dWEN;
  word_t [N-1:0]    iaddr, daddr, dstore;
  logic  [N-1:0]    iwait, dwait;
  word_t [N-1:0]    iload, dload;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;
  logic             ram_err;
  arb_state_t       state_o;
  logic             rr_ptr_o;

  memory_arbiter #(.CPUS(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
    .state_o(state_o), .rr_ptr_o(rr_ptr_o)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  // Entry: {core[3:0], isD[3:0], load[31:0]}
  logic [39:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [N-1:0] prev_iwait = '1;
  logic [N-1:0] prev_dwait = '1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic [39:0] obs);
    logic [39:0] exp_w;
    done_cnt++;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected actual=0x%0h expected=none @%0t", obs, $time);
    end else begin
      exp_w = exp_q.pop_front();
      check("sb_done", obs, exp_w);
    end
  endtask

  task automatic monitor();
    int          n_done;
    logic [31:0] leak;
    n_done = 0;
    leak   = '0;
    for (int c = 0; c < N; c++) begin
      if (iwait[c]) leak |= iload[c];
      else begin
        n_done++;
        sb_pop({4'(c), 4'd0, iload[c]});
        check("i_pulse_len", 40'(prev_iwait[c]), 40'd1);
      end
      if (dwait[c]) leak |= dload[c];
      else begin
        n_done++;
        sb_pop({4'(c), 4'd1, dload[c]});
        check("d_pulse_len", 40'(prev_dwait[c]), 40'd1);
      end
    end
    check("idle_loads_zero", 40'(leak), 40'd0);
    if (n_done > 0) check("single_done", 40'(n_done), 40'd1);
    prev_iwait = iwait;
    prev_dwait = dwait;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  // Move to the middle of the next cycle; inputs set afterwards belong to it.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic sample();
    #1;
    monitor();
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    prev_iwait = '1;
    prev_dwait = '1;
  endtask

  task automatic check_ram(input string tag, input logic ren, input logic wen, input word_t addr,
                           input logic [N-1:0] iw, input logic [N-1:0] dw, input arb_state_t st);
    check({tag, "_ren"},   40'(ramREN),  40'(ren));
    check({tag, "_wen"},   40'(ramWEN),  40'(wen));
    check({tag, "_addr"},  40'(ramaddr), 40'(addr));
    check({tag, "_iwait"}, 40'(iwait),   40'(iw));
    check({tag, "_dwait"}, 40'(dwait),   40'(dw));
    check({tag, "_state"}, 40'(state_o), 40'(st));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] iren, dren, dwen;
    word_t        ia0, da0, ds0;
    ramstate_t    rs;
    word_t        rl;
    logic         push;
    logic [39:0]  sb;
    logic         e_ren, e_wen;
    word_t        e_addr, e_store;
    logic [N-1:0] e_iwait, e_dwait;
    arb_state_t   e_st;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int  budget;
    // Core0 fetch at 0x40, two BUSY cycles then ACCESS.
    vecs[0] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, FREE,   32'h0,        1'b1, {4'd0, 4'd0, 32'hDEADBEEF}, 1'b0, 1'b0, 32'h0,   32'h0,        2'b11, 2'b11, IDLE};
    vecs[1] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, BUSY,   32'h0,        1'b0, 40'h0,                      1'b1, 1'b0, 32'h40,  32'h0,        2'b11, 2'b11, SERVE};
    vecs[2] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, BUSY,   32'h0,        1'b0, 40'h0,                      1'b1, 1'b0, 32'h40,  32'h0,        2'b11, 2'b11, SERVE};
    vecs[3] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, ACCESS, 32'hDEADBEEF, 1'b0, 40'h0,                      1'b1, 1'b0, 32'h40,  32'h0,        2'b10, 2'b11, SERVE};
    vecs[4] = '{2'b00, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, FREE,   32'h0,        1'b0, 40'h0,                      1'b0, 1'b0, 32'h0,   32'h0,        2'b11, 2'b11, IDLE};
    // Core0 fetch and write together: write first, fetch after one IDLE.
    vecs[5] = '{2'b01, 2'b00, 2'b01, 32'h44, 32'h100, 32'h12345678, ACCESS, 32'h0, 1'b1, {4'd0, 4'd1, 32'h0},     1'b0, 1'b0, 32'h0,   32'h0,        2'b11, 2'b11, IDLE};
    vecs[6] = '{2'b01, 2'b00, 2'b01, 32'h44, 32'h100, 32'h12345678, ACCESS, 32'h0, 1'b0, 40'h0,                   1'b0, 1'b1, 32'h100, 32'h12345678, 2'b11, 2'b10, SERVE};
    vecs[7] = '{2'b01, 2'b00, 2'b00, 32'h44, 32'h100, 32'h12345678, ACCESS, 32'h0, 1'b1, {4'd0, 4'd0, 32'hCAFEF00D}, 1'b0, 1'b0, 32'h0, 32'h0,        2'b11, 2'b11, IDLE};
    vecs[8] = '{2'b01, 2'b00, 2'b00, 32'h44, 32'h0, 32'h0, ACCESS, 32'hCAFEF00D, 1'b0, 40'h0,                      1'b1, 1'b0, 32'h44,  32'h0,        2'b10, 2'b11, SERVE};
    vecs[9] = '{2'b00, 2'b00, 2'b00, 32'h44, 32'h0, 32'h0, FREE,   32'h0,        1'b0, 40'h0,                      1'b0, 1'b0, 32'h0,   32'h0,        2'b11, 2'b11, IDLE};

    // ---- reset with no requests: quiet for 10 cycles ----
    do_reset();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      ramstate = ramstate_t'($urandom_range(0, 3));
      ramload  = $urandom;
      sample();
      check_ram($sformatf("quiet%0d", k), 1'b0, 1'b0, 32'h0, 2'b11, 2'b11, IDLE);
      check("quiet_store", 40'(ramstore), 40'd0);
      check("quiet_err",   40'(ram_err),  40'd0);
    end
    check("reset_ptr", 40'(rr_ptr_o), 40'd0);

    // ---- table: fetch with BUSY, write-before-fetch ----
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      iREN = vecs[i].iren; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
      iaddr[0] = vecs[i].ia0; daddr[0] = vecs[i].da0; dstore[0] = vecs[i].ds0;
      ramstate = vecs[i].rs; ramload = vecs[i].rl;
      if (vecs[i].push) exp_q.push_back(vecs[i].sb);
      sample();
      check_ram($sformatf("v%0d", i), vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr,
                vecs[i].e_iwait, vecs[i].e_dwait, vecs[i].e_st);
      check($sformatf("v%0d_store", i), 40'(ramstore), 40'(vecs[i].e_store));
    end
    check("ptr_after_table", 40'(rr_ptr_o), 40'd1);

    // ---- core1 fetch withdrawn during second BUSY cycle ----
    next_cycle(); iREN = 2'b10; iaddr[1] = 32'h80; ramstate = FREE; sample();
    check_ram("abort_c0", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11, IDLE);
    next_cycle(); ramstate = BUSY; sample();
    check_ram("abort_c1", 1'b1, 1'b0, 32'h80, 2'b11, 2'b11, SERVE);
    next_cycle(); iREN = 2'b00; sample();
    check_ram("abort_c2", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11, SERVE);
    next_cycle(); ramstate = FREE; sample();
    check_ram("abort_c3", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11, IDLE);
    check("abort_ptr", 40'(rr_ptr_o), 40'd1);

    // ---- fairness: both cores hold dREN for 6 transactions ----
    do_reset();
    done_cnt = 0;
    for (int t = 0; t < 6; t++) exp_q.push_back({4'(t % 2), 4'd1, 32'h5A5A0000});
    budget = 0;
    next_cycle();
    dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300;
    ramstate = ACCESS; ramload = 32'h5A5A0000;
    sample();
    while (done_cnt < 6 && budget < 40) begin
      next_cycle();
      sample();
      budget++;
    end
    check("fair_count", 40'(done_cnt), 40'd6);
    next_cycle(); dREN = 2'b00; ramstate = FREE; sample();
    check_ram("fair_end", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11, IDLE);

    // ---- ERROR twice then ACCESS: sticky ram_err ----
    next_cycle(); dREN = 2'b01; daddr[0] = 32'h240; ramstate = FREE;
    exp_q.push_back({4'd0, 4'd1, 32'h0BADF00D});
    sample();
    next_cycle(); ramstate = ERROR; sample();
    check_ram("err_c1", 1'b1, 1'b0, 32'h240, 2'b11, 2'b11, SERVE);
    check("err_c1_flag", 40'(ram_err), 40'd0);
    next_cycle(); sample();
    check_ram("err_c2", 1'b1, 1'b0, 32'h240, 2'b11, 2'b11, SERVE);
    check("err_c2_flag", 40'(ram_err), 40'd1);
    next_cycle(); ramstate = ACCESS; ramload = 32'h0BADF00D; sample();
    check_ram("err_c3", 1'b1, 1'b0, 32'h240, 2'b11, 2'b10, SERVE);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); dREN = 2'b00; ramstate = FREE; sample();
      check("err_sticky", 40'(ram_err), 40'd1);
    end

    // ---- reset in the middle of a SERVE aborts at once ----
    next_cycle(); iREN = 2'b01; iaddr[0] = 32'h60; ramstate = BUSY; sample();
    next_cycle(); sample();
    check_ram("mid_serve", 1'b1, 1'b0, 32'h60, 2'b11, 2'b11, SERVE);
    nRST = 1'b0;
    #1;
    check_ram("mid_rst", 1'b0, 1'b0, 32'h0, 2'b11, 2'b11, IDLE);
    check("mid_rst_err", 40'(ram_err), 40'd0);
    iREN = 2'b00;
    @(negedge CLK);
    nRST = 1'b1;

    check("sb_empty", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
